// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 decryption control path.
// Output decode for the round sequencer lives here so datapath-side code can reuse it.
package aes_pkg;

    localparam int unsigned AES_NR    = 10;
    localparam int unsigned AES_NCOL  = 4;
    localparam int unsigned AES_KEY_W = 128;
    localparam int unsigned AES_RND_W = 4;
    localparam int unsigned AES_COL_W = 2;
    localparam int unsigned AES_OP_W  = 3;

    typedef enum logic [AES_OP_W-1:0] {
        OP_NOP = 3'd0,
        OP_ARK = 3'd1,
        OP_ISR = 3'd2,
        OP_ISB = 3'd3,
        OP_IMC = 3'd4
    } aes_op_t;

    typedef enum logic [3:0] {
        ST_IDLE, ST_KEYREQ, ST_KEYWAIT, ST_LOAD, ST_ARK0,
        ST_ISR, ST_ISB, ST_ARK, ST_IMC, ST_DONE
    } aes_ctrl_state_t;

    typedef struct packed {
        logic                 key_exp_start;
        logic                 msg_ld;
        logic                 state_ld;
        aes_op_t              op_sel;
        logic [AES_RND_W-1:0] round;
        logic [AES_COL_W-1:0] col_sel;
        logic                 busy;
        logic                 done;
    } aes_ctrl_out_t;

    // Moore output decode of a sequencer state and its round/column registers.
    function automatic aes_ctrl_out_t aes_ctrl_decode(
        input aes_ctrl_state_t      st,
        input logic [AES_RND_W-1:0] rnd,
        input logic [AES_COL_W-1:0] col
    );
        aes_ctrl_out_t o;
        o      = '0;
        o.busy = (st != ST_IDLE) && (st != ST_DONE);
        if (o.busy) o.round = rnd;
        case (st)
            ST_KEYREQ: o.key_exp_start = 1'b1;
            ST_LOAD:   o.msg_ld        = 1'b1;
            ST_ARK0, ST_ARK: begin
                o.state_ld = 1'b1;
                o.op_sel   = OP_ARK;
            end
            ST_ISR: begin
                o.state_ld = 1'b1;
                o.op_sel   = OP_ISR;
            end
            ST_ISB: begin
                o.state_ld = 1'b1;
                o.op_sel   = OP_ISB;
            end
            ST_IMC: begin
                o.state_ld = 1'b1;
                o.op_sel   = OP_IMC;
                o.col_sel  = col;
            end
            ST_DONE:   o.done = 1'b1;
            default:   ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/aes_dec_ctrl_if.sv
// Handshake and control bus between the decrypt sequencer, the top-level
// requester, the key schedule and the AES datapath.
interface aes_dec_ctrl_if;
    import aes_pkg::*;

    logic                 AES_START;
    logic [AES_KEY_W-1:0] AES_KEY;
    logic                 KEY_EXP_DONE;
    logic                 KEY_EXP_START;
    logic                 MSG_LD;
    logic                 STATE_LD;
    aes_op_t              OP_SEL;
    logic [AES_RND_W-1:0] ROUND;
    logic [AES_COL_W-1:0] COL_SEL;
    logic                 BUSY;
    logic                 AES_DONE;

    modport master (
        output AES_START, AES_KEY, KEY_EXP_DONE,
        input  KEY_EXP_START, MSG_LD, STATE_LD, OP_SEL, ROUND, COL_SEL, BUSY, AES_DONE
    );

    modport slave (
        input  AES_START, AES_KEY, KEY_EXP_DONE,
        output KEY_EXP_START, MSG_LD, STATE_LD, OP_SEL, ROUND, COL_SEL, BUSY, AES_DONE
    );

endinterface

// File: rtl/aes_dec_ctrl.sv
// AES-128 decryption round sequencer: key request, state load, then 10 inverse rounds.
// Optional key cache under AES_DEC_CTRL_KEY_CACHE_EN skips re-expansion of an unchanged key.
module aes_dec_ctrl
    import aes_pkg::*;
(
    input  logic           CLK,
    input  logic           RESET,
    aes_dec_ctrl_if.slave  bus
);

    aes_ctrl_state_t      state_q, state_d;
    logic [AES_RND_W-1:0] rnd_q, rnd_d;
    logic [AES_COL_W-1:0] col_q, col_d;
    aes_ctrl_out_t        out_q, out_d;
    logic                 key_hit;

`ifdef AES_DEC_CTRL_KEY_CACHE_EN
    logic [AES_KEY_W-1:0] key_q, key_d;
    logic                 key_vld_q, key_vld_d;

    assign key_hit = key_vld_q && (bus.AES_KEY == key_q);

    // Capture the key being expanded; it becomes valid once expansion completes.
    always_comb begin
        key_d     = key_q;
        key_vld_d = key_vld_q;
        if (state_q == ST_KEYREQ) begin
            key_d     = bus.AES_KEY;
            key_vld_d = 1'b0;
        end else if ((state_q == ST_KEYWAIT) && bus.KEY_EXP_DONE) begin
            key_vld_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            key_q     <= '0;
            key_vld_q <= 1'b0;
        end else begin
            key_q     <= key_d;
            key_vld_q <= key_vld_d;
        end
    end
`else
    logic unused_key;
    assign unused_key = ^bus.AES_KEY;
    assign key_hit    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        col_d   = col_q;
        case (state_q)
            ST_IDLE:    if (bus.AES_START) state_d = key_hit ? ST_LOAD : ST_KEYREQ;
            ST_KEYREQ:  state_d = ST_KEYWAIT;
            ST_KEYWAIT: if (bus.KEY_EXP_DONE) state_d = ST_LOAD;
            ST_LOAD: begin
                rnd_d   = AES_RND_W'(AES_NR);
                state_d = ST_ARK0;
            end
            ST_ARK0: begin
                rnd_d   = AES_RND_W'(AES_NR - 1);
                state_d = ST_ISR;
            end
            ST_ISR:     state_d = ST_ISB;
            ST_ISB:     state_d = ST_ARK;
            ST_ARK: begin
                if (rnd_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    col_d   = '0;
                    state_d = ST_IMC;
                end
            end
            // One InvMixColumns pass per column, then on to the next lower round.
            ST_IMC: begin
                if (col_q == AES_COL_W'(AES_NCOL - 1)) begin
                    col_d   = '0;
                    rnd_d   = (rnd_q != '0) ? rnd_q - AES_RND_W'(1) : '0;
                    state_d = ST_ISR;
                end else begin
                    col_d   = col_q + AES_COL_W'(1);
                end
            end
            ST_DONE:    if (!bus.AES_START) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        out_d = aes_ctrl_decode(state_d, rnd_d, col_d);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            rnd_q   <= '0;
            col_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            col_q   <= col_d;
            out_q   <= out_d;
        end
    end

    assign bus.KEY_EXP_START = out_q.key_exp_start;
    assign bus.MSG_LD        = out_q.msg_ld;
    assign bus.STATE_LD      = out_q.state_ld;
    assign bus.OP_SEL        = out_q.op_sel;
    assign bus.ROUND         = out_q.round;
    assign bus.COL_SEL       = out_q.col_sel;
    assign bus.BUSY          = out_q.busy;
    assign bus.AES_DONE      = out_q.done;

endmodule
